// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and helpers for the receiver and transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchroniser for an asynchronous single-bit input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver with mid-bit sampling and framing check.
//               Optional even parity stage enabled by UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int c_cnt_w      = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic                 w_rx_s;
    logic                 w_par_bad;
    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_frame_err;

    uart_sync2 #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (RxD),
        .o_q (w_rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    // Even parity: the data bits plus the parity bit must XOR to zero.
    assign w_par_bad  = ^{r_shift, r_par_bit};
    assign parity_err = r_parity_err;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == c_half) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_last) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == c_last) begin
                        r_cnt     <= '0;
                        r_par_bit <= w_rx_s;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (r_cnt == c_last) begin
                        r_cnt       <= '0;
                        r_frame_err <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= w_par_bad;
`endif
                        if (w_rx_s) begin
                            // Back to IDLE at mid-stop leaves half a bit for the next start edge.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            if (!w_par_bad) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end
                        end else begin
                            r_state <= WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = r_data;
    assign rx_valid  = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver (CLKS_PER_BIT = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 100_000;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = CPB / 2 - 1;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int valid_cyc  = -1;
    int t_start    = 0;
    int busy_drops = 0;
    bit in_data    = 1'b0;

    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    logic [7:0]   exp_data = 8'h00;
    logic         exp_ferr = 1'b0;
    logic         exp_perr = 1'b0;

    uart_receiver #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RxD        (RxD),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(data_out);
            valid_cyc = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        RxD = v;
        for (int i = 0; i < CPB; i++) begin
            @(negedge clk);
            if (in_data && !busy) busy_drops++;
        end
    endtask

    // Drives one frame and updates the expected outcome from the line rules.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        bit good;
        busy_drops = 0;
        t_start    = cyc;
        send_bit(1'b0);
        in_data = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        in_data = 1'b0;
`ifdef UART_RX_PARITY_EN
        send_bit(par_ok ? ^b : ~^b);
`endif
        send_bit(stop_ok);
        good = stop_ok && (PAR_BITS == 0 || par_ok);
        if (good) begin
            exp_q.push_back(b);
            exp_data = b;
        end
        exp_ferr = !stop_ok;
        exp_perr = (PAR_BITS != 0) && !par_ok;
    endtask

    task automatic verify(input string tag);
        check({tag, "_pulses"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check({tag, "_data_out"}, data_out, exp_data);
        check({tag, "_frame_err"}, frame_err, exp_ferr);
        check({tag, "_parity_err"}, parity_err, exp_perr);
        check({tag, "_busy_in_frame"}, busy_drops, 0);
    endtask

    initial begin
        int lat;
        int lat_exp;
        logic [7:0] b;
        bit stop_ok;
        bit par_ok;

        tick(3);
        check("rst_data_out", data_out, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        rst = 1'b0;
        tick(5);

        // Single frame with latency measurement
        send_frame(8'hA5, 1'b1, 1'b1);
        lat     = valid_cyc - t_start;
        lat_exp = 2 + (HALF + 1) + (9 + PAR_BITS) * CPB;
        check("latency", (lat >= lat_exp - 1 && lat <= lat_exp + 1) ? lat_exp : lat, lat_exp);
        verify("a5");
        tick(10);

        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        verify("b2b");
        tick(10);

        // Short low glitch must be rejected without touching any flag
        RxD = 1'b0;
        tick(5);
        RxD = 1'b1;
        tick(30);
        check("glitch_busy", busy, 0);
        verify("glitch");

        // Bad stop bit followed by a held-low break
        send_frame(8'h3C, 1'b0, 1'b1);
        tick(40);
        check("break_busy", busy, 1);
        RxD = 1'b1;
        tick(4);
        check("break_release_busy", busy, 0);
        verify("ferr");
        send_frame(8'h11, 1'b1, 1'b1);
        verify("after_ferr");
        tick(10);

        // Reset in the middle of data bit 4
        b = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        RxD = b[4];
        tick(8);
        rst = 1'b1;
        RxD = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_data_out", data_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_parity_err", parity_err, 0);
        exp_data = 8'h00;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        tick(40);
        verify("midrst");
        send_frame(8'h81, 1'b1, 1'b1);
        verify("after_rst");
        tick(10);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        verify("par_good");
        tick(5);
        send_frame(8'h07, 1'b1, 1'b0);
        verify("par_bad");
        tick(5);
`endif

        for (int n = 0; n < 24; n++) begin
            b       = 8'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            par_ok  = ($urandom_range(0, 5) != 0);
            send_frame(b, stop_ok, par_ok);
            verify("rnd");
            if (!stop_ok) begin
                RxD = 1'b1;
                tick(4 + $urandom_range(0, 10));
            end else if ($urandom_range(0, 2) != 0) begin
                tick($urandom_range(1, 20));
            end
        end
        tick(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver. It is the receive-side counterpart of the existing Transmitter block on the same serial link.
- Samples asynchronous RxD at mid-bit using a clk-based bit timer and delivers each good byte with a one-cycle valid strobe.
- Flags framing errors, and parity errors when the optional parity feature is compiled in.
- Sits beside the Transmitter in the UART top and feeds a byte consumer (display, register or FIFO) in the clk domain.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division), clocks per bit; must be >= 4. Derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- RxD  input  1  asynchronous serial input; idle high.
- data_out  output  8  last good received byte, LSB received first.
- rx_valid  output  1  one-cycle strobe; data_out is valid in the same cycle.
- busy  output  1  high while a frame is in progress (state != IDLE).
- frame_err  output  1  stop bit sampled low on the last completed frame.
- parity_err  output  1  parity mismatch on the last completed frame; constant 0 when parity is disabled.

Behaviour:
- Interface fixes: one clock, clk. Reset is synchronous and active-high, rst.
- Reset values: data_out=0, rx_valid=0, busy=0, frame_err=0, parity_err=0, state=IDLE, counters=0. Both synchroniser flops reset to 1.
- Input synchroniser: 2-flop chain on RxD produces rx_s. All decisions use rx_s only.
- Counters:
  - cnt is $clog2(CLKS_PER_BIT) bits wide and resets to 0 on every state change.
  - bit_idx is 3 bits wide.
  - HALF = CLKS_PER_BIT/2 - 1.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: at cnt==HALF, re-check rx_s.
  - rx_s==0: go to DATA with bit_idx=0.
  - rx_s==1: glitch. Return to IDLE; no flags change.
- DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of an 8-bit shift register (shift right, LSB first) and increment bit_idx.
  - After bit_idx 7 wraps: go to PARITY if enabled, else STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1 (and no parity error): data_out<=shift register, rx_valid=1 for exactly one cycle, frame_err<=0. Go to IDLE.
  - rx_s==0: frame_err<=1, rx_valid stays 0, data_out unchanged. Go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This covers a break condition (line held low) so that no false start is detected.
- Error flags are updated only at frame completion; each completed frame sets or clears them. A glitch-rejected start touches nothing.
- Latency: rx_valid rises 2 + (HALF+1) + 9*CLKS_PER_BIT (+1 with parity) cycles after the RxD falling edge, ±1 cycle.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. IDLE is re-entered at stop-bit mid-point, leaving half a bit of margin.
- rst asserted mid-frame: the next edge forces reset values; the partial byte is discarded and no rx_valid is issued.
- No ready/ack handshake. The consumer must capture data_out on rx_valid; a new good frame overwrites it.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA. It samples the bit at cnt==CLKS_PER_BIT-1, using even parity (XOR of the 8 data bits and the parity bit must be 0).
  - On mismatch, parity_err<=1 at frame completion, rx_valid is suppressed and data_out is unchanged. parity_err<=0 on a good frame.
  - frame_err is evaluated independently.
- Undefined: no PARITY state, and parity_err is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - localparams DATA_BITS=8, IDLE_LEVEL=1'b1;
  - a function computing CLKS_PER_BIT from CLK_FREQ and BAUD_RATE.
- The Transmitter shares this package.
- One natural sub-module: uart_sync2, the 2-flop synchroniser with reset value 1. It is reusable for Transmit_btn paths.

Test Plan (CLK_FREQ=1_600_000, BAUD_RATE=100_000, so CLKS_PER_BIT=16):
1. Send 0xA5 8N1 -> one rx_valid pulse with data_out=0xA5, frame_err=0, at 2+8+144 cycles ±1 after the start edge; busy high throughout the frame.
2. Send 0x00, then 0xFF back-to-back with no idle gap -> two rx_valid pulses carrying 0x00, then 0xFF; no errors.
3. Pulse RxD low for 5 clk -> no rx_valid, busy returns to 0, flags unchanged.
4. Send 0x3C with the stop bit forced low, then hold RxD low for 40 clk, then release -> frame_err=1, no rx_valid, data_out keeps its previous value. A following good 0x11 -> rx_valid, data_out=0x11, frame_err=0.
5. Assert rst for 1 cycle at bit 4 of 0x5A -> all outputs return to reset values and no rx_valid for that frame; the next frame 0x81 is received correctly.
6. With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> rx_valid, data_out=0x07. Send 0x07 with parity bit 0 -> parity_err=1 and no rx_valid.
